// File: rtl/activation_table_fetch_pkg.sv
// rtl/activation_table_fetch_pkg.sv - shared widths, types and index helper for activation units
package activation_table_fetch_pkg;
  localparam int DATA_W  = 8;
  localparam int FRAC_W  = 4;
  localparam int IDX_W   = DATA_W - FRAC_W;
  localparam int ENTRIES = 2 ** IDX_W;

  // Shift applied by the downstream interpolator; tied to the input fraction width.
  localparam int INTERP_FRAC_SHIFT = FRAC_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [IDX_W-1:0]         idx_t;

  // Inverting the integer-part MSB maps signed -8..+7 onto table slots 0..15.
  function automatic idx_t value_to_idx(input sample_t value);
    return {~value[DATA_W-1], value[DATA_W-2:FRAC_W]};
  endfunction

  function automatic sample_t value_to_frac(input sample_t value);
    return {{(DATA_W-FRAC_W){1'b0}}, value[FRAC_W-1:0]};
  endfunction
endpackage

// File: rtl/activation_sample_table.sv
// rtl/activation_sample_table.sv - sample register file, one write port, two combinational reads
module activation_sample_table
  import activation_table_fetch_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    we,
  input  idx_t    waddr,
  input  sample_t wdata,
  input  idx_t    raddr_a,
  output sample_t rdata_a,
  input  idx_t    raddr_b,
  output sample_t rdata_b
);
  sample_t mem [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle fetch returns the old sample.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/activation_table_fetch.sv
// rtl/activation_table_fetch.sv - split Q4.4 input into index/fraction and fetch neighbouring samples
module activation_table_fetch
  import activation_table_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] next__data,
  output logic [DATA_W-1:0] remaining,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_addr,
  input  logic [DATA_W-1:0] tbl_wdata
);
  logic    s1_valid;
  idx_t    s1_idx;
  sample_t s1_rem;
  idx_t    s1_idx_next;
  sample_t rd_base;
  sample_t rd_next;
  logic    s2_adv;
  logic    s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Upper neighbour saturates at the last slot so 0x7F interpolates flat.
  assign s1_idx_next = (s1_idx == idx_t'(ENTRIES - 1)) ? s1_idx : s1_idx + idx_t'(1);

  activation_sample_table u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (tbl_we),
    .waddr   (tbl_addr),
    .wdata   (tbl_wdata),
    .raddr_a (s1_idx),
    .rdata_a (rd_base),
    .raddr_b (s1_idx_next),
    .rdata_b (rd_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_rem   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_idx <= value_to_idx(in_value);
        s1_rem <= value_to_frac(in_value);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      base       <= '0;
      next__data <= '0;
      remaining  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        base       <= rd_base;
        next__data <= rd_next;
        remaining  <= s1_rem;
      end
    end
  end
endmodule
